// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a runtime-loadable pattern, length and
// overlap mode. A single-bit stream qualified by in_valid is shifted into a
// history register while the detector is hunting. A registered one-cycle pulse
// is raised when the newest len samples equal the configured pattern, and a
// saturating counter tracks how many matches have been seen.
// Out of reset the detector looks for "1011" with overlapping matches, so
// existing users need no configuration.
module seq_detector_param #(
    parameter int                 MAX_LEN         = 8,
    parameter int                 LEN_W           = $clog2(MAX_LEN) + 1,
    parameter int                 CNT_W           = 16,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(8'b0000_1011),
    parameter int                 DEFAULT_LEN     = 4,
    parameter logic               DEFAULT_OVERLAP = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sequence_in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clear,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic               active
);

    // Two-state controller: UNCFG after an illegal load, HUNT otherwise.
    localparam logic [0:0] ST_UNCFG = 1'b0;
    localparam logic [0:0] ST_HUNT  = 1'b1;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_DEF = LEN_W'(DEFAULT_LEN);
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    // Registered state and configuration.
    logic [0:0]         state_reg,   state_next;
    logic [MAX_LEN-1:0] pattern_reg, pattern_next;
    logic [LEN_W-1:0]   len_reg,     len_next;
    logic               overlap_reg, overlap_next;
    logic [MAX_LEN-1:0] hist_reg,    hist_next;
    logic [LEN_W-1:0]   fill_reg,    fill_next;
    logic               det_reg,     det_next;
    logic [CNT_W-1:0]   count_reg,   count_next;
    logic               err_reg,     err_next;

    // Datapath helpers.
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [MAX_LEN-1:0] bit_ok;
    logic               cfg_len_ok;
    logic               sample_take;
    logic               match_hit;

    // History as it would look after accepting the current sample; the
    // match is judged on this post-shift view.
    assign hist_shift = {hist_reg[MAX_LEN-2:0], sequence_in};

    // Fill count saturates at MAX_LEN: once the history is full, every
    // further sample keeps it full.
    assign fill_inc = (fill_reg >= LEN_MAX) ? LEN_MAX : (fill_reg + LEN_W'(1));

    // Per-bit compare; positions at or above the active length are
    // don't-care and always agree.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
            assign bit_ok[gi] = (LEN_W'(gi) >= len_reg) ||
                                (hist_shift[gi] == pattern_reg[gi]);
        end
    endgenerate

    assign cfg_len_ok = (cfg_len != '0) && (cfg_len <= LEN_MAX);

    // A sample is accepted only while hunting and only when no config load
    // competes for the same edge (the load wins and the sample is dropped).
    assign sample_take = (state_reg == ST_HUNT) && in_valid && !cfg_load;

    assign match_hit = sample_take && (fill_inc >= len_reg) && (&bit_ok);

    // Next-state logic for configuration, history, pulse and counter.
    always_comb begin
        state_next   = state_reg;
        pattern_next = pattern_reg;
        len_next     = len_reg;
        overlap_next = overlap_reg;
        hist_next    = hist_reg;
        fill_next    = fill_reg;
        err_next     = err_reg;
        det_next     = 1'b0;
        count_next   = count_reg;

        if (cfg_load) begin
            // Any load restarts the search from an empty history.
            hist_next = '0;
            fill_next = '0;
            if (cfg_len_ok) begin
                pattern_next = cfg_pattern;
                len_next     = cfg_len;
                overlap_next = cfg_overlap;
                state_next   = ST_HUNT;
                err_next     = 1'b0;
            end else begin
                // Keep the stale config in the registers but park the
                // detector so it is never used.
                state_next = ST_UNCFG;
                err_next   = 1'b1;
            end
        end else if (sample_take) begin
            hist_next = hist_shift;
            fill_next = fill_inc;
            if (match_hit) begin
                det_next = 1'b1;
                // Non-overlapping mode: the next match needs len fresh bits.
                if (!overlap_reg) begin
                    fill_next = '0;
                end
            end
        end

        // Clear takes priority over a coincident increment.
        if (cnt_clear) begin
            count_next = '0;
        end else if (match_hit && (count_reg != CNT_SAT)) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    // State register with synchronous active-low reset to the defaults.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg   <= ST_HUNT;
            pattern_reg <= DEFAULT_PATTERN;
            len_reg     <= LEN_DEF;
            overlap_reg <= DEFAULT_OVERLAP;
            hist_reg    <= '0;
            fill_reg    <= '0;
            det_reg     <= 1'b0;
            count_reg   <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pattern_reg <= pattern_next;
            len_reg     <= len_next;
            overlap_reg <= overlap_next;
            hist_reg    <= hist_next;
            fill_reg    <= fill_next;
            det_reg     <= det_next;
            count_reg   <= count_next;
            err_reg     <= err_next;
        end
    end

    assign detector_out = det_reg;
    assign match_count  = count_reg;
    assign cfg_err      = err_reg;
    assign active       = (state_reg == ST_HUNT);

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: two instances (16-bit and 4-bit counters)
// share one stimulus stream. Directed steps follow the detector's use cases,
// then a randomized phase; every edge is compared with a queue-based model.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;

    logic       clock;
    logic       reset;
    logic       sequence_in;
    logic       in_valid;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       cnt_clear;

    logic        det16, err16, act16;
    logic [15:0] cnt16;
    logic        det4, err4, act4;
    logic [3:0]  cnt4;

    seq_detector_param #(.MAX_LEN(8), .CNT_W(16)) dut16 (
        .clock(clock), .reset(reset), .sequence_in(sequence_in),
        .in_valid(in_valid), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clear(cnt_clear),
        .detector_out(det16), .match_count(cnt16), .cfg_err(err16),
        .active(act16)
    );

    seq_detector_param #(.MAX_LEN(8), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .sequence_in(sequence_in),
        .in_valid(in_valid), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cnt_clear(cnt_clear),
        .detector_out(det4), .match_count(cnt4), .cfg_err(err4),
        .active(act4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;

    // Reference model: samples since the last restart, newest at the back.
    bit         q[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ov;
    bit         m_hunt;
    bit         m_err;
    bit         m_det;
    int         m_cnt16;
    int         m_cnt4;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Apply the detector's rules to the inputs present at this edge.
    task automatic model_edge();
        bit hit;
        hit = 0;
        if (!reset) begin
            m_pat = 8'b0000_1011; m_len = 4; m_ov = 1;
            q.delete();
            m_hunt = 1; m_err = 0; m_det = 0; m_cnt16 = 0; m_cnt4 = 0;
            return;
        end
        if (cfg_load) begin
            q.delete();
            if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
                m_pat = cfg_pattern; m_len = int'(cfg_len); m_ov = cfg_overlap;
                m_hunt = 1; m_err = 0;
            end else begin
                m_hunt = 0; m_err = 1;
            end
        end else if (m_hunt && in_valid) begin
            q.push_back(sequence_in);
            if (q.size() > MAX_LEN) void'(q.pop_front());
            if (q.size() >= m_len) begin
                hit = 1;
                for (int i = 0; i < m_len; i++)
                    if (q[q.size() - 1 - i] != m_pat[i]) hit = 0;
            end
            if (hit && !m_ov) q.delete();
        end
        m_det = hit;
        if (cnt_clear) begin
            m_cnt16 = 0; m_cnt4 = 0;
        end else if (hit) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4 < 15) m_cnt4++;
        end
    endtask

    // One clock edge: update the model, then compare every output just after.
    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        n_txn++;
        $display("txn %0d rst=%b ld=%b len=%0d v=%b d=%b clr=%b | det=%b cnt=%0d cnt4=%0d err=%b act=%b",
                 n_txn, reset, cfg_load, cfg_len, in_valid, sequence_in, cnt_clear,
                 det16, cnt16, cnt4, err16, act16);
        chk("det16", 32'(det16), 32'(m_det));
        chk("cnt16", 32'(cnt16), 32'(m_cnt16));
        chk("err16", 32'(err16), 32'(m_err));
        chk("act16", 32'(act16), 32'(m_hunt));
        chk("det4",  32'(det4),  32'(m_det));
        chk("cnt4",  32'(cnt4),  32'(m_cnt4));
    endtask

    task automatic cyc(input logic r, input logic v, input logic b,
                       input logic clr);
        reset = r; in_valid = v; sequence_in = b; cfg_load = 1'b0;
        cnt_clear = clr;
        tick();
    endtask

    task automatic ld(input logic [7:0] p, input int l, input logic o);
        reset = 1'b1; cfg_load = 1'b1; cfg_pattern = p; cfg_len = 4'(l);
        cfg_overlap = o; in_valid = 1'b0; cnt_clear = 1'b0;
        tick();
        cfg_load = 1'b0;
    endtask

    // Send n bits, bits[n-1] first, one valid sample per cycle.
    task automatic send_bits(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, 1'b1, bits[i], 1'b0);
    endtask

    initial begin
        reset = 1'b0; sequence_in = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
        cnt_clear = 1'b0;

        // Reset state and default overlapping "1011".
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("rst_det", 32'(det16), 32'd0);
        chk("rst_act", 32'(act16), 32'd1);
        send_bits(8'b0101_1011, 7);
        chk("default_two_matches", 32'(cnt16), 32'd2);

        // Non-overlapping mode: only the first of the two matches.
        ld(8'b0000_1011, 4, 1'b0);
        send_bits(8'b0101_1011, 7);
        chk("no_overlap_count", 32'(cnt16), 32'd3);

        // Illegal lengths park the detector.
        ld(8'hFF, 0, 1'b1);
        send_bits(8'hFF, 8);
        ld(8'hFF, 9, 1'b1);
        chk("bad_len_err", 32'(err16), 32'd1);
        chk("bad_len_act", 32'(act16), 32'd0);
        send_bits(8'hFF, 8);
        chk("bad_len_count", 32'(cnt16), 32'd3);

        // Full-width pattern.
        ld(8'b1100_1010, 8, 1'b1);
        chk("good_len_err", 32'(err16), 32'd0);
        send_bits(8'b1100_1010, 8);
        chk("len8_pulse", 32'(det16), 32'd1);

        // Idle gaps between samples keep the history.
        ld(8'b0000_1011, 4, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("gap_pulse", 32'(det16), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("gap_fall", 32'(det16), 32'd0);

        // Load coincident with the completing sample drops it.
        send_bits(8'b0000_0101, 3);
        reset = 1'b1; cfg_load = 1'b1; cfg_pattern = 8'b0000_1011;
        cfg_len = 4'd4; cfg_overlap = 1'b1; in_valid = 1'b1;
        sequence_in = 1'b1; cnt_clear = 1'b0;
        tick();
        cfg_load = 1'b0;
        chk("load_drops_pulse", 32'(det16), 32'd0);

        // Clear coincident with a match: pulse still appears, count is 0.
        send_bits(8'b0000_0101, 3);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("clr_pulse", 32'(det16), 32'd1);
        chk("clr_count", 32'(cnt16), 32'd0);

        // len=1 and 4-bit counter saturation.
        ld(8'b0000_0001, 1, 1'b1);
        send_bits(8'hFF, 8);
        send_bits(8'hFF, 8);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("sat_cnt4", 32'(cnt4), 32'd15);
        chk("sat_cnt16", 32'(cnt16), 32'd17);

        // Reset mid-pattern discards the partial history.
        ld(8'b0000_1011, 4, 1'b1);
        send_bits(8'b0000_0101, 3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("midrst_pulse", 32'(det16), 32'd0);
        chk("midrst_count", 32'(cnt16), 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            reset = (r < 2) ? 1'b0 : 1'b1;
            cfg_load = (r >= 2 && r < 6) ? 1'b1 : 1'b0;
            cfg_pattern = 8'($urandom);
            cfg_len = 4'($urandom_range(0, 9));
            cfg_overlap = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            sequence_in = 1'($urandom);
            cnt_clear = ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Serial bit-pattern detector with a runtime-loadable pattern, length and overlap mode. It replaces the fixed 4-bit "1011" Moore detector. It sits on a single-bit serial stream with a sample-valid qualifier and raises a one-cycle registered match pulse. It also keeps a saturating match counter for status readout. Reset defaults reproduce "1011" overlapping detection, so existing users need no configuration.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, $clog2(MAX_LEN)+1, width of length fields
CNT_W, 16, width of match counter
DEFAULT_PATTERN, 8'b0000_1011, pattern loaded at reset (right-aligned)
DEFAULT_LEN, 4, pattern length loaded at reset
DEFAULT_OVERLAP, 1, overlap mode loaded at reset

Ports:
clock  input  1  single clock, all logic on rising edge
reset  input  1  reset; one clock; reset is synchronous and active-low
sequence_in  input  1  serial data bit
in_valid  input  1  sequence_in is sampled on edges where in_valid=1
cfg_load  input  1  load cfg_pattern/cfg_len/cfg_overlap this edge
cfg_pattern  input  MAX_LEN  pattern, right-aligned; bit cfg_len-1 is received first, bit 0 last
cfg_len  input  LEN_W  pattern length, valid range 1..MAX_LEN
cfg_overlap  input  1  1 = overlapping matches allowed, 0 = restart after match
cnt_clear  input  1  clear match_count
detector_out  output  1  one-cycle match pulse, registered
match_count  output  CNT_W  saturating count of matches
cfg_err  output  1  sticky: last load had illegal cfg_len
active  output  1  1 when in HUNT state

Behaviour:
- Reset (reset=0 at an edge):
  - pattern/len/overlap take the DEFAULT_* values.
  - History and fill count clear to 0.
  - detector_out=0, match_count=0, cfg_err=0.
  - State goes to HUNT, active=1.
- State machine with two states, UNCFG and HUNT.
  - HUNT: on every edge with in_valid=1, the history shifts left and sequence_in enters at bit 0. fill = min(fill+1, MAX_LEN).
  - UNCFG: samples are ignored, detector_out is held 0, active=0.
- Config load (cfg_load=1):
  - If 1<=cfg_len<=MAX_LEN: latch all three config fields, clear history and fill, go to HUNT, clear cfg_err.
  - Otherwise: go to UNCFG, set cfg_err=1, leave the old config unused.
  - On every load, detector_out<=0 on that edge. match_count is unchanged.
- Match condition: evaluated on the post-shift history.
  - Requires fill>=len and history[len-1:0]==pattern[len-1:0].
  - Pattern bits above len are don't-care.
- Latency:
  - detector_out is 1 for exactly the cycle following the accepting edge that completes the match.
  - It returns to 0 on the next edge regardless of in_valid.
  - Back-to-back matches on consecutive valid edges give a continuous high.
- Overlap modes:
  - Overlap=1: history is retained after a match.
  - Overlap=0: on a match, fill is cleared to 0 on the same edge, so the next match needs len fresh samples.
- match_count:
  - Increments by 1 on the edge a match is registered.
  - Saturates at 2^CNT_W-1 with no wrap.
- Priorities:
  - reset > cfg_load > in_valid. A sample coincident with cfg_load is dropped.
  - cnt_clear coincident with a match: the count becomes 0; clear wins over increment.
  - The match pulse is still produced.
- in_valid=0 edges: history, fill and state are unchanged; detector_out falls to 0.
- len=1: every valid sample equal to pattern[0] matches.
- Reset asserted mid-pattern: partial history is discarded and the defaults are restored.

Test Plan:
- Reset, then stream 1,0,1,1,0,1,1 with in_valid=1 every cycle -> detector_out high one cycle after the 4th and 7th samples; match_count=2.
- Load pattern 1011, len 4, overlap=0; stream 1,0,1,1,0,1,1 -> single pulse after the 4th sample only; match_count increments by 1.
- Load len=0, then len=9 (MAX_LEN=8) -> cfg_err=1, active=0, no pulses on any stream. Then load pattern 8'b1100_1010, len 8 -> cfg_err=0, and a pulse after the 8th bit of 1,1,0,0,1,0,1,0.
- Stream 1,0,1 with in_valid gaps of 3 idle cycles between bits, then 1 -> single pulse after the final valid edge; detector_out stays 0 during the idle cycles.
- Drive cfg_load on the same edge as the matching 4th sample -> no pulse, history cleared; also assert cnt_clear on a match edge -> match_count=0 with detector_out=1.
- CNT_W=4: produce 17 matches -> match_count=15 (held). Assert reset=0 mid-pattern after 1,0,1, then send 1 -> no pulse, match_count=0.
